// File: rtl/sd_cmd_sequencer_pkg.sv
// Shared encodings for the SD command sequencer: FSM states, response types,
// command-field positions and interrupt status bit positions.
package sd_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitResp,
    StCheck,
    StComplete
  } state_e;

  typedef enum logic [1:0] {
    RespNone      = 2'b00,
    RespLong      = 2'b01,
    RespShort     = 2'b10,
    RespShortBusy = 2'b11
  } resp_type_e;

  // COMMAND register fields
  localparam int unsigned RespTypeMsb = 1;
  localparam int unsigned RespTypeLsb = 0;
  localparam int unsigned CmdCrcEnBit = 3;
  localparam int unsigned CmdIdxEnBit = 4;
  localparam int unsigned CmdIdxMsb   = 13;
  localparam int unsigned CmdIdxLsb   = 8;
  localparam int unsigned TmoExpMsb   = 3;

  // Start bit 0 followed by transmission bit 1
  localparam logic [1:0] FrameStartBits = 2'b01;

  // Interrupt status bit positions
  localparam int unsigned ErrTimeoutBit     = 0;
  localparam int unsigned ErrCrcBit         = 1;
  localparam int unsigned ErrIndexBit       = 3;
  localparam int unsigned NrmCmdCompleteBit = 0;
  localparam int unsigned NrmErrorBit       = 15;

  localparam int unsigned SwRstCmdBit = 1;

endpackage

// File: rtl/sd_cmd_timeout.sv
// Response timeout counter: limit = 2^(TIMEOUT_BASE + exponent), saturating to
// all-ones when the exponent sum does not fit in TIMEOUT_W bits.
module sd_cmd_timeout #(
  parameter int unsigned TIMEOUT_BASE = 8,
  parameter int unsigned TIMEOUT_W    = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [3:0] exponent,
  output logic       expired
);

  localparam logic [TIMEOUT_W-1:0] One = TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] count_q, count_d, limit;
  int unsigned          exp_sum;

  always_comb begin
    exp_sum = TIMEOUT_BASE + 32'(exponent);
    if (exp_sum >= TIMEOUT_W) begin
      limit = '1;
    end else begin
      limit = One << exp_sum;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + One;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == (limit - One));

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Runs one SD command transaction: frame to PHY, wait for / check the response
// or time out, then report status with a single-cycle command_complete.
module sd_cmd_sequencer
  import sd_cmd_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_BASE = 8,
  parameter int unsigned TIMEOUT_W    = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cmd_start,
  input  logic [15:0]  command,
  input  logic [31:0]  argument,
  input  logic [15:0]  timeout_control,
  input  logic [2:0]   software_reset,
  output logic         phy_req,
  input  logic         phy_ack,
  output logic [39:0]  cmd_frame,
  output logic [1:0]   resp_expected,
  input  logic         phy_resp_valid,
  input  logic [127:0] phy_resp,
  input  logic [5:0]   phy_resp_index,
  input  logic         phy_crc_error,
  output logic [127:0] response_o,
  output logic [15:0]  normal_interrupt_status_o,
  output logic [15:0]  error_interrupt_status_o,
  output logic         command_complete,
  output logic         cmd_inhibit
);

  state_e         state_q, state_d;
  logic [15:0]    cmd_q;
  logic [3:0]     tmo_exp_q;
  logic [39:0]    frame_q;
  logic [127:0]   resp_q;
  logic           crc_err_q;
  logic [5:0]     resp_idx_q;
  logic [15:0]    err_q, err_d, nrm_q, nrm_d;
  resp_type_e     resp_type;
  logic           cmd_line_rst, cmd_accept, tmo_expired, unused_bits;

  assign cmd_line_rst = software_reset[SwRstCmdBit];
  assign cmd_accept   = (state_q == StIdle) && cmd_start && !cmd_line_rst;
  assign resp_type    = resp_type_e'(cmd_q[RespTypeMsb:RespTypeLsb]);
  assign unused_bits  = ^{cmd_q[15:14], cmd_q[7:5], cmd_q[2], timeout_control[15:4],
                          software_reset[2], software_reset[0]};

  sd_cmd_timeout #(
    .TIMEOUT_BASE (TIMEOUT_BASE),
    .TIMEOUT_W    (TIMEOUT_W)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (cmd_line_rst || ((state_q == StSend) && phy_ack)),
    .enable   (state_q == StWaitResp),
    .exponent (tmo_exp_q),
    .expired  (tmo_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (cmd_accept) state_d = StSend;
      StSend:     if (phy_ack) state_d = (resp_type == RespNone) ? StComplete : StWaitResp;
      // A response arriving on the limit cycle takes priority over the timeout
      StWaitResp: begin
        if (phy_resp_valid) begin
          state_d = StCheck;
        end else if (tmo_expired) begin
          state_d = StComplete;
        end
      end
      StCheck:    state_d = StComplete;
      StComplete: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    if (cmd_line_rst) state_d = StIdle;
  end

  always_comb begin
    phy_req          = (state_q == StSend);
    command_complete = (state_q == StComplete);
    cmd_inhibit      = (state_q == StSend) || (state_q == StWaitResp) || (state_q == StCheck);
  end

  always_comb begin
    err_d = err_q;
    nrm_d = nrm_q;
    if (cmd_accept) begin
      err_d = '0;
      nrm_d = '0;
    end
    if ((state_q == StWaitResp) && !phy_resp_valid && tmo_expired) begin
      err_d[ErrTimeoutBit] = 1'b1;
    end
    if (state_q == StCheck) begin
      err_d[ErrCrcBit]   = cmd_q[CmdCrcEnBit] & crc_err_q;
      // 136-bit responses carry no index field
      err_d[ErrIndexBit] = cmd_q[CmdIdxEnBit] & (resp_type != RespLong) &
                           (resp_idx_q != cmd_q[CmdIdxMsb:CmdIdxLsb]);
    end
    if (state_d == StComplete) begin
      nrm_d[NrmCmdCompleteBit] = 1'b1;
      nrm_d[NrmErrorBit]       = |err_d;
    end
    if (cmd_line_rst) begin
      err_d = '0;
      nrm_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_q      <= '0;
      tmo_exp_q  <= '0;
      frame_q    <= '0;
      resp_q     <= '0;
      crc_err_q  <= 1'b0;
      resp_idx_q <= '0;
      err_q      <= '0;
      nrm_q      <= '0;
    end else begin
      err_q <= err_d;
      nrm_q <= nrm_d;
      if (cmd_line_rst) begin
        resp_q <= '0;
      end else begin
        if (cmd_accept) begin
          cmd_q     <= command;
          tmo_exp_q <= timeout_control[TmoExpMsb:0];
          frame_q   <= {FrameStartBits, command[CmdIdxMsb:CmdIdxLsb], argument};
        end
        if ((state_q == StWaitResp) && phy_resp_valid) begin
          resp_q     <= phy_resp;
          crc_err_q  <= phy_crc_error;
          resp_idx_q <= phy_resp_index;
        end
      end
    end
  end

  assign cmd_frame                 = frame_q;
  assign resp_expected             = cmd_q[RespTypeMsb:RespTypeLsb];
  assign response_o                = resp_q;
  assign normal_interrupt_status_o = nrm_q;
  assign error_interrupt_status_o  = err_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed self-checking bench for sd_cmd_sequencer.
module tb_sd_cmd_sequencer;

  logic         clock = 1'b0;
  logic         reset;
  logic         cmd_start;
  logic [15:0]  command;
  logic [31:0]  argument;
  logic [15:0]  timeout_control;
  logic [2:0]   software_reset;
  logic         phy_req;
  logic         phy_ack;
  logic [39:0]  cmd_frame;
  logic [1:0]   resp_expected;
  logic         phy_resp_valid;
  logic [127:0] phy_resp;
  logic [5:0]   phy_resp_index;
  logic         phy_crc_error;
  logic [127:0] response_o;
  logic [15:0]  normal_interrupt_status_o;
  logic [15:0]  error_interrupt_status_o;
  logic         command_complete;
  logic         cmd_inhibit;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] RespA = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] RespB = 128'hdead_beef_cafe_f00d_1111_2222_3333_4444;
  localparam logic [127:0] RespC = 128'h5555_aaaa_0f0f_f0f0_1234_5678_9abc_def0;

  always #5 clock = ~clock;

  sd_cmd_sequencer dut (
    .clock                     (clock),
    .reset                     (reset),
    .cmd_start                 (cmd_start),
    .command                   (command),
    .argument                  (argument),
    .timeout_control           (timeout_control),
    .software_reset            (software_reset),
    .phy_req                   (phy_req),
    .phy_ack                   (phy_ack),
    .cmd_frame                 (cmd_frame),
    .resp_expected             (resp_expected),
    .phy_resp_valid            (phy_resp_valid),
    .phy_resp                  (phy_resp),
    .phy_resp_index            (phy_resp_index),
    .phy_crc_error             (phy_crc_error),
    .response_o                (response_o),
    .normal_interrupt_status_o (normal_interrupt_status_o),
    .error_interrupt_status_o  (error_interrupt_status_o),
    .command_complete          (command_complete),
    .cmd_inhibit               (cmd_inhibit)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_cmd(input logic [15:0] cmd, input logic [31:0] arg,
                           input logic [15:0] tc);
    command         = cmd;
    argument        = arg;
    timeout_control = tc;
    cmd_start       = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic ack_now;
    phy_ack = 1'b1;
    tick();
    phy_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset           = 1'b0;
    cmd_start       = 1'b0;
    command         = '0;
    argument        = '0;
    timeout_control = '0;
    software_reset  = '0;
    phy_ack         = 1'b0;
    phy_resp_valid  = 1'b0;
    phy_resp        = '0;
    phy_resp_index  = '0;
    phy_crc_error   = 1'b0;
    #12;
    n_checks++;
    if ({phy_req, command_complete, cmd_inhibit, resp_expected} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {phy_req, command_complete, cmd_inhibit, resp_expected});
    end
    n_checks++;
    if ({cmd_frame, response_o, normal_interrupt_status_o, error_interrupt_status_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: frame %h resp %h nrm %h err %h expected all zero",
               cmd_frame, response_o, normal_interrupt_status_o, error_interrupt_status_o);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_no_resp;
    start_cmd(16'h0000, 32'h0000_0000, 16'h0000);
    n_checks++;
    if (cmd_frame !== 40'h40_0000_0000) begin
      n_fail++;
      $display("FAIL cmd0_frame: got %h expected 4000000000", cmd_frame);
    end
    n_checks++;
    if ({phy_req, cmd_inhibit} !== 2'b11) begin
      n_fail++;
      $display("FAIL cmd0_send: req/inhibit got %b expected 11", {phy_req, cmd_inhibit});
    end
    tick();
    n_checks++;
    if (phy_req !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd0_req_hold: got %b expected 1", phy_req);
    end
    ack_now();
    n_checks++;
    if ({command_complete, phy_req, cmd_inhibit} !== 3'b100) begin
      n_fail++;
      $display("FAIL cmd0_complete: cc/req/inh got %b expected 100",
               {command_complete, phy_req, cmd_inhibit});
    end
    n_checks++;
    if ({normal_interrupt_status_o, error_interrupt_status_o} !== {16'h0001, 16'h0000}) begin
      n_fail++;
      $display("FAIL cmd0_status: nrm %h err %h expected 0001 0000",
               normal_interrupt_status_o, error_interrupt_status_o);
    end
    tick();
    n_checks++;
    if ({command_complete, normal_interrupt_status_o} !== {1'b0, 16'h0001}) begin
      n_fail++;
      $display("FAIL cmd0_pulse_hold: cc %b nrm %h expected 0 0001",
               command_complete, normal_interrupt_status_o);
    end
  endtask

  task automatic test_back_to_back;
    // immediate ack: complete in the third cycle counting the cmd_start cycle
    start_cmd(16'h0000, 32'h1234_5678, 16'h0000);
    ack_now();
    n_checks++;
    if (command_complete !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: command_complete got %b expected 1", command_complete);
    end
    tick();
  endtask

  task automatic test_resp_ok;
    start_cmd(16'h111A, 32'h0000_0200, 16'h0000);
    n_checks++;
    if ({cmd_frame, resp_expected} !== {40'h51_0000_0200, 2'b10}) begin
      n_fail++;
      $display("FAIL cmd17_frame: got %h/%b expected 5100000200/10", cmd_frame, resp_expected);
    end
    ack_now();
    n_checks++;
    if ({phy_req, cmd_inhibit} !== 2'b01) begin
      n_fail++;
      $display("FAIL cmd17_wait: req/inh got %b expected 01", {phy_req, cmd_inhibit});
    end
    repeat (3) tick();
    phy_resp_valid = 1'b1;
    phy_resp       = RespA;
    phy_resp_index = 6'd17;
    phy_crc_error  = 1'b0;
    tick();
    phy_resp_valid = 1'b0;
    n_checks++;
    if (response_o !== RespA) begin
      n_fail++;
      $display("FAIL cmd17_resp: got %h expected %h", response_o, RespA);
    end
    tick();
    n_checks++;
    if ({command_complete, normal_interrupt_status_o, error_interrupt_status_o} !==
        {1'b1, 16'h0001, 16'h0000}) begin
      n_fail++;
      $display("FAIL cmd17_ok_status: cc %b nrm %h err %h expected 1 0001 0000",
               command_complete, normal_interrupt_status_o, error_interrupt_status_o);
    end
    tick();
  endtask

  task automatic test_resp_err;
    start_cmd(16'h111A, 32'h0000_0200, 16'h0000);
    n_checks++;
    if (normal_interrupt_status_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL status_clear_on_start: nrm got %h expected 0000", normal_interrupt_status_o);
    end
    ack_now();
    tick();
    phy_resp_valid = 1'b1;
    phy_resp       = RespB;
    phy_resp_index = 6'd5;
    phy_crc_error  = 1'b1;
    tick();
    phy_resp_valid = 1'b0;
    phy_crc_error  = 1'b0;
    tick();
    n_checks++;
    if ({command_complete, normal_interrupt_status_o, error_interrupt_status_o} !==
        {1'b1, 16'h8001, 16'h000A}) begin
      n_fail++;
      $display("FAIL cmd17_err_status: cc %b nrm %h err %h expected 1 8001 000a",
               command_complete, normal_interrupt_status_o, error_interrupt_status_o);
    end
    tick();
  endtask

  task automatic test_timeout;
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 1'b0;
    start_cmd(16'h0202, 32'h0000_0000, 16'h0000);
    ack_now();
    for (int i = 1; i <= 1000 && !seen; i++) begin
      tick();
      if (command_complete === 1'b1) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    n_checks++;
    if (!seen || cyc != 256) begin
      n_fail++;
      $display("FAIL timeout_latency: seen %0b after %0d cycles expected 256", seen, cyc);
    end
    n_checks++;
    if ({normal_interrupt_status_o, error_interrupt_status_o} !== {16'h8001, 16'h0001}) begin
      n_fail++;
      $display("FAIL timeout_status: nrm %h err %h expected 8001 0001",
               normal_interrupt_status_o, error_interrupt_status_o);
    end
    tick();
  endtask

  task automatic test_timeout_race;
    // response on the very cycle the counter hits the limit
    start_cmd(16'h0202, 32'h0000_0000, 16'h0000);
    ack_now();
    repeat (255) tick();
    phy_resp_valid = 1'b1;
    phy_resp       = RespC;
    phy_resp_index = 6'd2;
    tick();
    phy_resp_valid = 1'b0;
    tick();
    n_checks++;
    if ({command_complete, normal_interrupt_status_o, error_interrupt_status_o} !==
        {1'b1, 16'h0001, 16'h0000}) begin
      n_fail++;
      $display("FAIL race_status: cc %b nrm %h err %h expected 1 0001 0000",
               command_complete, normal_interrupt_status_o, error_interrupt_status_o);
    end
    n_checks++;
    if (response_o !== RespC) begin
      n_fail++;
      $display("FAIL race_resp: got %h expected %h", response_o, RespC);
    end
    tick();
  endtask

  task automatic test_soft_reset;
    int n_cc;
    n_cc = 0;
    start_cmd(16'h0202, 32'h0000_0000, 16'h0000);
    ack_now();
    repeat (5) tick();
    software_reset = 3'b010;
    command        = 16'h0000;
    cmd_start      = 1'b1;
    tick();
    software_reset = 3'b000;
    cmd_start      = 1'b0;
    n_checks++;
    if ({cmd_inhibit, phy_req, command_complete} !== 3'b000) begin
      n_fail++;
      $display("FAIL swrst_ctrl: inh/req/cc got %b expected 000",
               {cmd_inhibit, phy_req, command_complete});
    end
    n_checks++;
    if ({response_o, normal_interrupt_status_o, error_interrupt_status_o} !== '0) begin
      n_fail++;
      $display("FAIL swrst_clear: resp %h nrm %h err %h expected all zero",
               response_o, normal_interrupt_status_o, error_interrupt_status_o);
    end
    repeat (300) begin
      tick();
      if (command_complete === 1'b1) n_cc++;
    end
    n_checks++;
    if (n_cc != 0) begin
      n_fail++;
      $display("FAIL swrst_no_complete: got %0d pulses expected 0", n_cc);
    end
    start_cmd(16'h0000, 32'h0000_0000, 16'h0000);
    n_checks++;
    if ({phy_req, cmd_inhibit} !== 2'b11) begin
      n_fail++;
      $display("FAIL swrst_restart: req/inh got %b expected 11", {phy_req, cmd_inhibit});
    end
    ack_now();
    n_checks++;
    if ({command_complete, normal_interrupt_status_o} !== {1'b1, 16'h0001}) begin
      n_fail++;
      $display("FAIL swrst_restart_done: cc %b nrm %h expected 1 0001",
               command_complete, normal_interrupt_status_o);
    end
    tick();
  endtask

  task automatic test_async_reset;
    start_cmd(16'h0000, 32'h0000_0000, 16'h0000);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({phy_req, cmd_inhibit} !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: req/inh got %b expected 00", {phy_req, cmd_inhibit});
    end
    n_checks++;
    if (cmd_frame !== 40'h0) begin
      n_fail++;
      $display("FAIL async_reset_frame: got %h expected 0", cmd_frame);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_no_resp();
    test_back_to_back();
    test_resp_ok();
    test_resp_err();
    test_timeout();
    test_timeout_race();
    test_soft_reset();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
- Sequences one SD command transaction from start to finish.
- Takes the COMMAND, ARGUMENT and TIMEOUT_CONTROL values from the register bank and hands a framed command to the command-line PHY.
- Waits for and checks the response, or times out.
- Returns the response plus interrupt status to the register bank with a one-cycle command_complete pulse.
- Sits between the host register bank and the command PHY.

Parameters:
- TIMEOUT_BASE, 8, base exponent: timeout limit = 2^(TIMEOUT_BASE + timeout_control[3:0]) clock cycles.
- TIMEOUT_W, 32, width of the timeout counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle pulse: host wrote the COMMAND register.
- command  in  16  [1:0] resp type (00 none, 01 136-bit, 10 48-bit, 11 48-bit busy); [3] CRC check enable; [4] index check enable; [13:8] command index.
- argument  in  32  command argument.
- timeout_control  in  16  [3:0] timeout exponent.
- software_reset  in  3  bit1 = CMD line reset (level).
- phy_req  out  1  request to PHY to transmit cmd_frame.
- phy_ack  in  1  PHY accepted the frame.
- cmd_frame  out  40  {2'b01, index[5:0], argument[31:0]}.
- resp_expected  out  2  copy of command[1:0] for the PHY.
- phy_resp_valid  in  1  one-cycle pulse: response received.
- phy_resp  in  128  response payload.
- phy_resp_index  in  6  index field of a 48-bit response.
- phy_crc_error  in  1  qualified by phy_resp_valid.
- response_o  out  128  latched response.
- normal_interrupt_status_o  out  16  bit0 command complete.
- error_interrupt_status_o  out  16  bit0 timeout, bit1 CRC, bit3 index.
- command_complete  out  1  one-cycle pulse.
- cmd_inhibit  out  1  high while a command is in flight.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; timeout counter 0.
- States: IDLE, SEND, WAIT_RESP, CHECK, COMPLETE.
- IDLE:
  - On cmd_start: latch command, argument and timeout exponent into internal copies; form cmd_frame; set cmd_inhibit.
  - Clear error_interrupt_status_o and normal_interrupt_status_o.
  - Go to SEND.
  - cmd_start in any other state is ignored.
- SEND:
  - phy_req=1, held until phy_ack.
  - On phy_ack (same cycle): phy_req drops next cycle.
  - If resp type==00, go to COMPLETE; otherwise go to WAIT_RESP with the counter cleared.
- WAIT_RESP:
  - Counter increments each cycle.
  - phy_resp_valid: latch phy_resp into response_o, register phy_crc_error and phy_resp_index, go to CHECK.
  - Counter reaching limit-1 without phy_resp_valid: set error bit0, go to COMPLETE.
  - phy_resp_valid in the same cycle as the limit: the response wins and no timeout is flagged.
  - Limit is computed at TIMEOUT_W width. An exponent sum of TIMEOUT_W or more saturates to all-ones.
- CHECK (1 cycle):
  - Error bit1 = CRC enable & crc_error.
  - Error bit3 = index enable & (resp_index != latched index).
  - Index check is skipped for resp type 01.
  - Go to COMPLETE.
- COMPLETE (1 cycle):
  - command_complete=1.
  - normal_interrupt_status_o[0]=1; normal bit15 = OR of error bits.
  - cmd_inhibit cleared.
  - Go to IDLE.
  - Status outputs hold until the next cmd_start.
- software_reset[1]=1 in any state:
  - Next cycle: IDLE, phy_req=0, cmd_inhibit=0, counter=0, status and response cleared.
  - No command_complete pulse.
  - cmd_start is ignored while software_reset[1] is high.
- Total latency for a no-response command with immediate phy_ack: cmd_start to command_complete = 3 cycles.

Decomposition:
- Shared package/defines:
  - state encodings;
  - response-type codes;
  - error and normal status bit positions;
  - command-field bit ranges.
- Sub-module sd_cmd_timeout: loadable counter with exponent-to-limit decode and an expired flag.

Test Plan:
- command=16'h0000 (CMD0, no resp), phy_ack 1 cycle after phy_req → cmd_frame=40'h4000000000; command_complete 1 pulse; normal=16'h0001; error=0.
- command=16'h111A (CMD17, 48-bit, CRC+index check), argument=32'h00000200, response with index 17 and no CRC error → response_o=phy_resp; error=0; normal=16'h0001.
- Same command, phy_resp_index=6'd5, phy_crc_error=1 → error=16'h000A; normal=16'h8001.
- command=16'h0202 (CMD2, 48-bit), timeout_control=0, no response → complete 256 cycles after WAIT_RESP entry; error=16'h0001.
- software_reset[1] pulsed during WAIT_RESP → no completion; cmd_inhibit=0 next cycle; a new cmd_start is then accepted.
- reset asserted mid-SEND → phy_req drops immediately, without waiting for a clock edge.
